// File: rtl/goose_scan_compositor.sv
// 640x480 VGA scan generator with a goose sprite composited over a flat background.
// Pixel pipeline: counters -> stage 1 (flags, sprite coords) -> stage 2 (registered pins).
module goose_scan_compositor #(
  parameter int          CLK_DIV  = 4,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          SPR_W    = 64,
  parameter int          SPR_H    = 96,
  parameter logic [11:0] BG_RGB   = 12'h6bf
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  goose_x,
  input  logic [9:0]  goose_y,
  output logic [9:0]  spr_x,
  output logic [9:0]  spr_y,
  input  logic [11:0] spr_rgb,
  input  logic        spr_hit,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] SPR_W11   = 11'(SPR_W);
  localparam logic [10:0] SPR_H11   = 11'(SPR_H);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Counters, divider and latched position
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic [9:0]    gx_q, gx_d;
  logic [9:0]    gy_q, gy_d;
  logic          fs_q, fs_d;

  // Stage 1
  logic          active1_q, active1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          in_box1_q, in_box1_d;
  logic [9:0]    spr_x_q, spr_x_d;
  logic [9:0]    spr_y_q, spr_y_d;

  // Stage 2 (pins)
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;

  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          in_box;
  logic [10:0]   h11, v11, gx11, gy11;

  assign tick   = (div_q == DIV_LAST);
  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  // Box bounds are compared in 11 bits so a box running past 1023 clips instead of wrapping.
  assign h11    = {1'b0, h_cnt_q};
  assign v11    = {1'b0, v_cnt_q};
  assign gx11   = {1'b0, gx_q};
  assign gy11   = {1'b0, gy_q};
  assign in_box = (h11 >= gx11) && (h11 < gx11 + SPR_W11) &&
                  (v11 >= gy11) && (v11 < gy11 + SPR_H11);

  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    fs_d      = 1'b0;
    active1_d = active1_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;
    in_box1_d = in_box1_q;
    spr_x_d   = spr_x_q;
    spr_y_d   = spr_y_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;

    if (tick) begin
      h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
      if (h_last) begin
        v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
      end

      // Position is only sampled as vertical blank begins, so a frame never tears.
      if (h_last && (v_cnt_q == V_ACT_END)) begin
        fs_d = 1'b1;
        gx_d = goose_x;
        gy_d = goose_y;
      end

      active1_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs1_d     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      vs1_d     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      in_box1_d = in_box;
      spr_x_d   = in_box ? h_cnt_q - gx_q : 10'd0;
      spr_y_d   = in_box ? v_cnt_q - gy_q : 10'd0;

      hsync_d = hs1_q;
      vsync_d = vs1_q;
      if (!active1_q) begin
        rgb_d = 12'h000;
      end else if (in_box1_q && spr_hit) begin
        rgb_d = spr_rgb;
      end else begin
        rgb_d = BG_RGB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      gx_q      <= 10'd0;
      gy_q      <= 10'd0;
      fs_q      <= 1'b0;
      active1_q <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      in_box1_q <= 1'b0;
      spr_x_q   <= 10'd0;
      spr_y_q   <= 10'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 12'h000;
    end else begin
      div_q     <= div_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      fs_q      <= fs_d;
      active1_q <= active1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      in_box1_q <= in_box1_d;
      spr_x_q   <= spr_x_d;
      spr_y_q   <= spr_y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign spr_x       = spr_x_q;
  assign spr_y       = spr_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule
